// File: rtl/frame_ram_pkg.sv
// frame_ram_pkg: shared types for the frame RAM writer.
// Provides the writer state encoding, default geometry and pixel type.
package frame_ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      WRITE,
      DONE
   } state_t;

   localparam int IMG_W_DEF = 256;
   localparam int IMG_H_DEF = 256;
   localparam int PIX_W     = 24;

   typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/frame_ram_addr_gen.sv
// frame_ram_addr_gen: raster position and RAM address tracker.
// Ports: clk, rst (sync, active-high); restart (SOF pixel consumed at
// addr 0), advance (next pixel on same line), next_line (line ended);
// x, y and addr give the position of the next pixel to be written.
import frame_ram_pkg::*;

module frame_ram_addr_gen #(
   parameter int ADDR_WIDTH = 16,
   parameter int IMG_W      = IMG_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  advance,
   input  logic                  next_line,
   output logic [ADDR_WIDTH-1:0] x,
   output logic [ADDR_WIDTH-1:0] y,
   output logic [ADDR_WIDTH-1:0] addr
);

   localparam logic [ADDR_WIDTH-1:0] W = ADDR_WIDTH'(IMG_W);

   logic [ADDR_WIDTH-1:0] line_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         line_base <= '0;
         addr      <= '0;
      end else if (restart) begin
         // the SOF pixel itself occupies addr 0
         x         <= ADDR_WIDTH'(1);
         y         <= '0;
         line_base <= '0;
         addr      <= ADDR_WIDTH'(1);
      end else if (next_line) begin
         x         <= '0;
         y         <= y + 1'b1;
         line_base <= line_base + W;
         addr      <= line_base + W;
      end else if (advance) begin
         x         <= x + 1'b1;
         addr      <= addr + 1'b1;
      end
   end

endmodule

// File: rtl/frame_ram_writer.sv
// frame_ram_writer: valid/ready pixel stream to raster-order RAM writes.
// Ports: clk, rst (sync, active-high), start (arm pulse); stream
// s_valid/s_ready/s_data/s_sof/s_eol; RAM port mem_wr_en/mem_addr/
// mem_wr_data (one cycle after acceptance); status busy, frame_done,
// err_len, err_sof. Defining FRAME_RAM_WRITER_CHECKSUM_EN adds
// checksum/checksum_valid (XOR of pixels written since the last SOF).
import frame_ram_pkg::*;

module frame_ram_writer #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = PIX_W,
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_sof,
   input  logic                  s_eol,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err_len,
`ifdef FRAME_RAM_WRITER_CHECKSUM_EN
   output logic                  err_sof,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic                  checksum_valid
`else
   output logic                  err_sof
`endif
);

   localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(IMG_W - 1);
   localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(IMG_H - 1);
   localparam bit                    MULTI  = (IMG_W > 1);

   state_t state;

   logic [ADDR_WIDTH-1:0] x;
   logic [ADDR_WIDTH-1:0] y;
   logic [ADDR_WIDTH-1:0] addr;

   logic acc;
   logic sof_hit;
   logic wr_px;
   logic x_last;
   logic y_last;
   logic line_end;
   logic advance;
   logic next_line;
   logic frame_end;

   assign s_ready = (state == ARMED) || (state == WRITE);
   assign busy    = s_ready;

   assign acc      = s_valid & s_ready;
   assign sof_hit  = acc & s_sof;
   assign wr_px    = acc & ~s_sof & (state == WRITE);
   assign x_last   = (x == X_LAST);
   assign y_last   = (y == Y_LAST);
   assign line_end = x_last | s_eol;

   // an early EOL on the final line closes the frame rather than
   // stepping past the last line of the buffer
   assign advance   = wr_px & ~line_end;
   assign next_line = wr_px & line_end & ~y_last;
   assign frame_end = wr_px & line_end & y_last;

   frame_ram_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .IMG_W      (IMG_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .restart   (sof_hit),
      .advance   (advance),
      .next_line (next_line),
      .x         (x),
      .y         (y),
      .addr      (addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_wr_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         frame_done  <= 1'b0;
         err_len     <= 1'b0;
         err_sof     <= 1'b0;
      end else begin
         mem_wr_en <= sof_hit | wr_px;
         if (sof_hit | wr_px) begin
            mem_addr    <= sof_hit ? '0 : addr;
            mem_wr_data <= s_data;
         end
         err_sof <= sof_hit & (state == WRITE);
         // length error: EOL and last column disagree
         err_len <= sof_hit ? (s_eol & MULTI)
                            : (wr_px & (x_last ^ s_eol));
         // pulse lands the cycle after the final write
         frame_done <= (state == DONE);
         unique case (state)
            IDLE:    if (start) state <= ARMED;
            ARMED:   if (sof_hit) state <= WRITE;
            WRITE:   if (frame_end) state <= DONE;
            DONE:    state <= CONTINUOUS ? ARMED : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FRAME_RAM_WRITER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;

   always_ff @(posedge clk) begin
      if (rst) begin
         csum           <= '0;
         checksum_valid <= 1'b0;
      end else begin
         checksum_valid <= (state == DONE);
         if (sof_hit) begin
            csum <= s_data;
         end else if (wr_px) begin
            csum <= csum ^ s_data;
         end
      end
   end

   assign checksum = csum;
`endif

endmodule
